// File: rtl/dfd_apb_seq_master.sv
// APB4 requester for DFD MMR bring-up: queued WRITE/READ/POLL commands,
// one APB transfer at a time, one response per command.
module dfd_apb_seq_master #(
    parameter int ADDR_WIDTH     = 23,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int PREADY_TIMEOUT = 256,
    parameter int POLL_MAX       = 1024,
    parameter int POLL_GAP       = 4,
    localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [DATA_WIDTH-1:0] cmd_mask,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [15:0]           rsp_attempts,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic [STRB_WIDTH-1:0] pstrb,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr,
    output logic                  busy
);

    localparam int PW       = $clog2(CMD_DEPTH);
    localparam int TW       = $clog2(PREADY_TIMEOUT + 1) + 1;
    localparam int GW       = $clog2(POLL_GAP + 1) + 1;
    localparam int PT_LAST  = (PREADY_TIMEOUT > 0) ? PREADY_TIMEOUT - 1 : 0;
    localparam int GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
    localparam bit PT_EN    = (PREADY_TIMEOUT > 0);

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_POLL  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_GAP,
        S_RESP
    } state_e;

    typedef struct packed {
        op_e                   op;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [DATA_WIDTH-1:0] mask;
        logic [STRB_WIDTH-1:0] strb;
    } cmd_t;

    state_e                state_q, state_d;
    cmd_t                  fifo_mem [CMD_DEPTH];
    cmd_t                  fifo_head;
    logic [PW:0]           wr_ptr, rd_ptr;
    logic                  full, empty, push, pop;

    op_e                   w_op;
    logic                  w_write;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata, w_mask;
    logic [STRB_WIDTH-1:0] w_strb;
    logic [TW-1:0]         wait_cnt;
    logic [GW-1:0]         gap_cnt;
    logic [15:0]           attempts;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q, timeout_q;

    logic                  poll_match, poll_last, pready_expired;
    logic [15:0]           attempts_inc;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign cmd_ready = !reset && !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && !empty;
    assign fifo_head = fifo_mem[rd_ptr[PW-1:0]];

    assign poll_match     = ((prdata & w_mask) == (w_wdata & w_mask));
    assign poll_last      = ({1'b0, attempts} + 17'd1) >= 17'(POLL_MAX);
    assign attempts_inc   = (attempts == 16'hFFFF) ? attempts : attempts + 16'd1;
    assign pready_expired = PT_EN && !pready && (wait_cnt == TW'(PT_LAST));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= '{op_e'(cmd_op), cmd_addr, cmd_wdata, cmd_mask, cmd_strb};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!empty) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: begin
                if (pready) begin
                    if (w_op != OP_POLL || pslverr || poll_match || poll_last) begin
                        state_d = S_RESP;
                    end else if (POLL_GAP == 0) begin
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_GAP;
                    end
                end else if (pready_expired) begin
                    state_d = S_RESP;
                end
            end
            S_GAP:    if (gap_cnt == GW'(GAP_LAST)) state_d = S_SETUP;
            S_RESP:   if (rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            w_op      <= OP_READ;
            w_write   <= 1'b0;
            w_addr    <= '0;
            w_wdata   <= '0;
            w_mask    <= '0;
            w_strb    <= '0;
            wait_cnt  <= '0;
            gap_cnt   <= '0;
            attempts  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                // reserved op is folded into READ here so the FSM only sees three ops
                w_op      <= (fifo_head.op == OP_RSVD) ? OP_READ : fifo_head.op;
                w_write   <= (fifo_head.op == OP_WRITE);
                w_addr    <= fifo_head.addr;
                w_wdata   <= fifo_head.wdata;
                w_mask    <= fifo_head.mask;
                w_strb    <= (fifo_head.op == OP_WRITE) ? fifo_head.strb : '0;
                attempts  <= '0;
                rdata_q   <= '0;
                err_q     <= 1'b0;
                timeout_q <= 1'b0;
            end
            case (state_q)
                S_SETUP: wait_cnt <= '0;
                S_ACCESS: begin
                    gap_cnt <= '0;
                    if (pready) begin
                        attempts <= attempts_inc;
                        rdata_q  <= (w_op == OP_WRITE) ? '0 : prdata;
                        err_q    <= pslverr;
                        if (w_op == OP_POLL && !pslverr && !poll_match && poll_last) begin
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (pready_expired) begin
                            timeout_q <= 1'b1;
                            rdata_q   <= '0;
                            err_q     <= 1'b0;
                        end
                    end
                end
                S_GAP: gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        psel         = (state_q == S_SETUP) || (state_q == S_ACCESS);
        penable      = (state_q == S_ACCESS);
        paddr        = w_addr;
        pwrite       = w_write;
        pstrb        = w_strb;
        pwdata       = w_wdata;
        rsp_valid    = (state_q == S_RESP);
        rsp_rdata    = rdata_q;
        rsp_err      = err_q;
        rsp_timeout  = timeout_q;
        rsp_attempts = attempts;
        busy         = (state_q != S_IDLE) || !empty;
    end

endmodule

// File: tb/tb_dfd_apb_seq_master.sv
// Self-checking bench: APB slave model, response scoreboard, vector table
// plus hand-written latency, FIFO-fill and mid-transfer reset sequences.
module tb_dfd_apb_seq_master;

    logic        clk, reset;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [22:0] cmd_addr;
    logic [31:0] cmd_wdata, cmd_mask;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [15:0] rsp_attempts;
    logic [22:0] paddr;
    logic        psel, penable, pwrite, pready, pslverr, busy;
    logic [3:0]  pstrb;
    logic [31:0] pwdata, prdata;

    dfd_apb_seq_master #(
        .ADDR_WIDTH(23), .DATA_WIDTH(32), .CMD_DEPTH(4),
        .PREADY_TIMEOUT(16), .POLL_MAX(8), .POLL_GAP(4)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .rsp_attempts(rsp_attempts),
        .paddr(paddr), .psel(psel), .penable(penable), .pstrb(pstrb), .pwrite(pwrite),
        .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr), .busy(busy)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        logic [15:0] att;
    } exp_t;

    typedef struct {
        logic [22:0] addr;
        logic        write;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int unsigned gap;
    } xfer_t;

    typedef struct {
        logic [1:0]  op;
        logic [22:0] addr;
        logic [31:0] wdata, mask;
        logic [3:0]  strb;
        int unsigned waits;
        bit          err, hang;
        int unsigned match_at;
        logic [31:0] sdata, sother;
        logic [31:0] e_rdata;
        bit          e_err, e_to;
        int unsigned e_att, e_xfers, e_acc;
    } vec_t;

    exp_t        sbq[$];
    xfer_t       xq[$];
    int unsigned n_chk = 0, n_pass = 0;

    int unsigned sl_waits = 0, sl_match_at = 0, sl_base = 0;
    bit          sl_err = 0, sl_hang = 0, sl_echo = 0;
    logic [31:0] sl_data = '0, sl_other = '0;
    int unsigned xfer_n = 0, acc_total = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // APB completer: decides pready/prdata away from the rising edge
    initial begin
        int unsigned cur_wait = 0, idle_cnt = 0, k;
        xfer_t r;
        pready = 0; prdata = '0; pslverr = 0;
        forever begin
            @(negedge clk);
            if (psel && penable) begin
                acc_total++;
                if (!sl_hang && cur_wait >= sl_waits) begin
                    xfer_n++;
                    k = xfer_n - sl_base;
                    pready  = 1;
                    pslverr = sl_err;
                    if (sl_echo) prdata = {9'd0, paddr};
                    else prdata = (sl_match_at != 0 && k >= sl_match_at) ? sl_data : sl_other;
                    r.addr = paddr; r.write = pwrite; r.strb = pstrb; r.wdata = pwdata; r.gap = idle_cnt;
                    xq.push_back(r);
                    idle_cnt = 0;
                    cur_wait = 0;
                end else begin
                    pready = 0;
                    cur_wait++;
                end
            end else begin
                pready = 0; pslverr = 0; cur_wait = 0;
                if (!psel) idle_cnt++;
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [22:0] addr, input logic [31:0] wd,
                            input logic [31:0] mk, input logic [3:0] st, input exp_t e);
        check("cmd_ready_before_send", cmd_ready, 1);
        cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_mask = mk; cmd_strb = st;
        sbq.push_back(e);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic get_rsp(input string nm);
        int unsigned n = 0;
        exp_t e;
        rsp_ready = 1;
        while (!rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            n_chk++;
            $display("FAIL %s_rsp_wait: no rsp_valid within %0d cycles", nm, n);
            return;
        end
        if (sbq.size() == 0) begin
            n_chk++;
            $display("FAIL %s_unexpected_rsp: got response, expected none", nm);
            @(negedge clk);
            return;
        end
        e = sbq.pop_front();
        check({nm, "_rdata"}, rsp_rdata, e.rdata);
        check({nm, "_err"}, rsp_err, e.err);
        check({nm, "_timeout"}, rsp_timeout, e.to);
        check({nm, "_attempts"}, rsp_attempts, e.att);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int xb;
        int unsigned ab;
        string nm;
        nm = $sformatf("v%0d", idx);
        sl_waits = v.waits; sl_err = v.err; sl_hang = v.hang; sl_match_at = v.match_at;
        sl_data = v.sdata; sl_other = v.sother; sl_echo = 0; sl_base = xfer_n;
        xb = xq.size(); ab = acc_total;
        send_cmd(v.op, v.addr, v.wdata, v.mask, v.strb, '{v.e_rdata, v.e_err, v.e_to, 16'(v.e_att)});
        get_rsp(nm);
        sl_hang = 0; sl_err = 0;
        check({nm, "_xfers"}, xq.size() - xb, v.e_xfers);
        check({nm, "_access_cycles"}, acc_total - ab, v.e_acc);
        for (int k = xb; k < xq.size(); k++) begin
            check({nm, "_paddr"}, xq[k].addr, v.addr);
            check({nm, "_pwrite"}, xq[k].write, v.op == 2'd0);
            check({nm, "_pstrb"}, xq[k].strb, (v.op == 2'd0) ? v.strb : 4'h0);
            check({nm, "_pwdata"}, xq[k].wdata, v.wdata);
            if (k > xb) check({nm, "_poll_gap"}, xq[k].gap, 4);
        end
    endtask

    vec_t vec[11];

    initial begin
        int xb;
        int unsigned seen;
        vec[0]  = '{2'd0, 23'h000248, 32'hDEADBEEF, 32'h0, 4'hF, 0, 0, 0, 0, 32'h0, 32'h0,
                    32'h0, 0, 0, 1, 1, 1};
        vec[1]  = '{2'd1, 23'h000248, 32'h0, 32'h0, 4'h0, 3, 0, 0, 1, 32'hDEADBEEF, 32'h0,
                    32'hDEADBEEF, 0, 0, 1, 1, 4};
        vec[2]  = '{2'd2, 23'h166040, 32'h1, 32'h1, 4'h0, 0, 0, 0, 3, 32'h1, 32'h0,
                    32'h1, 0, 0, 3, 3, 3};
        vec[3]  = '{2'd2, 23'h166044, 32'hA5, 32'hFF, 4'h0, 0, 0, 0, 0, 32'h0, 32'h5A,
                    32'h5A, 0, 1, 8, 8, 8};
        vec[4]  = '{2'd1, 23'h000100, 32'h0, 32'h0, 4'h0, 0, 0, 1, 0, 32'h0, 32'h0,
                    32'h0, 0, 1, 0, 0, 16};
        vec[5]  = '{2'd0, 23'h00024C, 32'h12345678, 32'h0, 4'h3, 0, 1, 0, 0, 32'h0, 32'h0,
                    32'h0, 1, 0, 1, 1, 1};
        vec[6]  = '{2'd1, 23'h000250, 32'h0, 32'h0, 4'h0, 1, 1, 0, 1, 32'hCAFEF00D, 32'h0,
                    32'hCAFEF00D, 1, 0, 1, 1, 2};
        vec[7]  = '{2'd2, 23'h000254, 32'h1, 32'h1, 4'hF, 0, 1, 0, 0, 32'h0, 32'h0,
                    32'h0, 1, 0, 1, 1, 1};
        vec[8]  = '{2'd3, 23'h000258, 32'h11, 32'h0, 4'hF, 0, 0, 0, 1, 32'h0BADF00D, 32'h0,
                    32'h0BADF00D, 0, 0, 1, 1, 1};
        vec[9]  = '{2'd2, 23'h00025C, 32'h30, 32'hF0, 4'h0, 2, 0, 0, 1, 32'h3C, 32'h0,
                    32'h3C, 0, 0, 1, 1, 3};
        vec[10] = '{2'd0, 23'h000260, 32'hA5A55A5A, 32'h0, 4'h5, 1, 0, 0, 0, 32'h0, 32'h0,
                    32'h0, 0, 0, 1, 1, 2};

        reset = 1; cmd_valid = 0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
        cmd_mask = '0; cmd_strb = '0; rsp_ready = 1;
        repeat (3) @(negedge clk);
        check("cmd_ready_in_reset", cmd_ready, 0);
        reset = 0;
        @(negedge clk);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_attempts", rsp_attempts, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);

        // latency: accept in c, psel c+2, penable c+3, rsp_valid c+4
        rsp_ready = 0;
        sl_waits = 0; sl_err = 0; sl_hang = 0; sl_echo = 0; sl_base = xfer_n;
        send_cmd(2'd0, 23'h000248, 32'hDEADBEEF, 32'h0, 4'hF, '{32'h0, 1'b0, 1'b0, 16'd1});
        check("lat_c1_psel", psel, 0);
        @(negedge clk);
        check("lat_c2_psel", psel, 1);
        check("lat_c2_penable", penable, 0);
        @(negedge clk);
        check("lat_c3_penable", penable, 1);
        check("lat_c3_paddr", paddr, 23'h248);
        check("lat_c3_pwrite", pwrite, 1);
        check("lat_c3_pwdata", pwdata, 32'hDEADBEEF);
        @(negedge clk);
        check("lat_c4_rsp_valid", rsp_valid, 1);
        check("lat_c4_psel", psel, 0);
        get_rsp("lat");

        for (int i = 0; i < 11; i++) run_vec(vec[i], i);

        // FIFO fill: 5 pushes, rsp held off, then drain in order
        rsp_ready = 0;
        sl_waits = 0; sl_err = 0; sl_hang = 0; sl_echo = 1; sl_base = xfer_n;
        xb = xq.size();
        for (int i = 0; i < 5; i++) begin
            check("fifo_cmd_ready", cmd_ready, 1);
            cmd_valid = 1; cmd_op = 2'd1; cmd_addr = 23'h001000 + 23'(i * 4);
            cmd_wdata = '0; cmd_mask = '0; cmd_strb = '0;
            sbq.push_back('{32'h001000 + 32'(i * 4), 1'b0, 1'b0, 16'd1});
            @(negedge clk);
        end
        cmd_valid = 0;
        check("fifo_full_cmd_ready", cmd_ready, 0);
        check("fifo_busy", busy, 1);
        repeat (4) @(negedge clk);
        check("fifo_rsp_held", rsp_valid, 1);
        get_rsp("fifo0");
        check("b2b_r1_psel", psel, 0);
        @(negedge clk);
        check("b2b_r2_psel", psel, 1);
        for (int i = 1; i < 5; i++) get_rsp($sformatf("fifo%0d", i));
        check("fifo_xfers", xq.size() - xb, 5);
        for (int i = 0; i < 5 && xb + i < xq.size(); i++)
            check("fifo_order", xq[xb + i].addr, 23'h001000 + 23'(i * 4));
        sl_echo = 0;

        // reset during ACCESS with two commands still queued
        sl_hang = 1;
        xb = xq.size();
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1; cmd_op = 2'd1; cmd_addr = 23'h002000 + 23'(i * 4);
            @(negedge clk);
        end
        cmd_valid = 0;
        seen = 0;
        while (!(psel && penable) && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        check("rstmid_in_access", psel && penable, 1);
        reset = 1;
        #1;
        check("rstmid_cmd_ready_low", cmd_ready, 0);
        @(negedge clk);
        check("rstmid_psel", psel, 0);
        check("rstmid_penable", penable, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_rsp_valid", rsp_valid, 0);
        reset = 0; sl_hang = 0;
        @(negedge clk);
        check("rstmid_cmd_ready", cmd_ready, 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid || psel || busy) seen++;
            @(negedge clk);
        end
        check("rstmid_no_activity", seen, 0);
        check("rstmid_no_xfers", xq.size() - xb, 0);
        check("sb_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
